// File: rtl/xyf_pkg.sv
// xyf shared types: channel mode encodings and
// the pattern each mode starts from.
package xyf_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_RUN   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  localparam logic [7:0] PAT_OFF   = 8'h00;
  localparam logic [7:0] PAT_ON    = 8'hFF;
  localparam logic [7:0] PAT_RUN   = 8'h01;
  localparam logic [7:0] PAT_BLINK = 8'hFF;

  function automatic logic [7:0] entry_pat(
    input mode_e m
  );
    logic [7:0] p;
    p = PAT_OFF;
    unique case (m)
      MODE_OFF:   p = PAT_OFF;
      MODE_ON:    p = PAT_ON;
      MODE_RUN:   p = PAT_RUN;
      MODE_BLINK: p = PAT_BLINK;
      default:    p = PAT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/xyf_if.sv
// xyf per-channel bundle: mode select and step
// tick toward a channel, pattern back out.
interface xyf_if;
  import xyf_pkg::*;

  logic [1:0] sel;
  logic       tick;
  logic [7:0] led;

  modport master (
    output sel,
    output tick,
    input  led
  );

  modport slave (
    input  sel,
    input  tick,
    output led
  );

endinterface

// File: rtl/xyf_channel.sv
// xyf_channel: one LED pattern generator; tracks
// the accepted mode and steps on the shared tick.
module xyf_channel
  import xyf_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  xyf_if.slave   io
);

  mode_e      r_mode;
  logic [7:0] r_pat;
  mode_e      w_sel;
  mode_e      w_mode_nxt;
  logic [7:0] w_pat_nxt;

  assign w_sel  = mode_e'(io.sel);
  assign io.led = r_pat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= MODE_OFF;
      r_pat  <= PAT_OFF;
    end else begin
      r_mode <= w_mode_nxt;
      r_pat  <= w_pat_nxt;
    end
  end

  // A mode change takes priority over a tick.
  always_comb begin
    w_mode_nxt = r_mode;
    w_pat_nxt  = r_pat;
    if (w_sel != r_mode) begin
      w_mode_nxt = w_sel;
      w_pat_nxt  = entry_pat(w_sel);
    end else if (io.tick) begin
      unique case (r_mode)
        MODE_RUN:   w_pat_nxt = {r_pat[6:0], r_pat[7]};
        MODE_BLINK: w_pat_nxt = ~r_pat;
        default:    w_pat_nxt = r_pat;
      endcase
    end
  end

endmodule

// File: rtl/xyf.sv
// xyf: three-channel LED pattern generator sharing
// one free-running step prescaler.
module xyf
  import xyf_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel_0,
  input  logic [1:0] sel_1,
  input  logic [1:0] sel_2,
  output logic [7:0] led_0,
  output logic [7:0] led_1,
  output logic [7:0] led_2
);

  localparam logic [23:0] CNT_MAX = 24'(TICK_DIV - 1);

  logic [23:0] r_cnt;
  logic        w_tick;

  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

  xyf_if w_ch0 ();
  xyf_if w_ch1 ();
  xyf_if w_ch2 ();

  assign w_ch0.sel  = sel_0;
  assign w_ch1.sel  = sel_1;
  assign w_ch2.sel  = sel_2;
  assign w_ch0.tick = w_tick;
  assign w_ch1.tick = w_tick;
  assign w_ch2.tick = w_tick;
  assign led_0      = w_ch0.led;
  assign led_1      = w_ch1.led;
  assign led_2      = w_ch2.led;

  xyf_channel u_ch0 (
    .i_clk   (clk),
    .i_rst_n (rst),
    .io      (w_ch0.slave)
  );

  xyf_channel u_ch1 (
    .i_clk   (clk),
    .i_rst_n (rst),
    .io      (w_ch1.slave)
  );

  xyf_channel u_ch2 (
    .i_clk   (clk),
    .i_rst_n (rst),
    .io      (w_ch2.slave)
  );

endmodule

// File: tb/tb_xyf.sv
// tb_xyf: randomized checks of xyf against a
// per-cycle behavioural model of the LED patterns.
module tb_xyf;

  localparam int TD = 4;

  logic       clk;
  logic       rst;
  logic [1:0] sel [3];
  logic [7:0] w_led [3];

  xyf_if ch0 ();
  xyf_if ch1 ();
  xyf_if ch2 ();

  assign ch0.sel  = sel[0];
  assign ch1.sel  = sel[1];
  assign ch2.sel  = sel[2];
  assign ch0.tick = 1'b0;
  assign ch1.tick = 1'b0;
  assign ch2.tick = 1'b0;
  assign w_led[0] = ch0.led;
  assign w_led[1] = ch1.led;
  assign w_led[2] = ch2.led;

  xyf #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst   (rst),
    .sel_0 (ch0.sel),
    .sel_1 (ch1.sel),
    .sel_2 (ch2.sel),
    .led_0 (ch0.led),
    .led_1 (ch1.led),
    .led_2 (ch2.led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         m_cnt;
  logic [1:0] m_mode [3];
  logic [7:0] m_pat [3];

  function automatic logic [7:0] entry(input logic [1:0] m);
    case (m)
      2'd1:    return 8'hFF;
      2'd2:    return 8'h01;
      2'd3:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 2'd0;
      m_pat[i]  = 8'h00;
    end
  endtask

  // One clock edge of the model, then settle 1 ns.
  task automatic step();
    bit tk;
    @(posedge clk);
    if (rst) begin
      tk = (m_cnt == TD - 1);
      m_cnt = (m_cnt + 1) % TD;
      for (int i = 0; i < 3; i++) begin
        if (sel[i] != m_mode[i]) begin
          m_mode[i] = sel[i];
          m_pat[i]  = entry(sel[i]);
        end else if (tk) begin
          if (m_mode[i] == 2'd2)
            m_pat[i] = (m_pat[i] == 8'h80) ? 8'h01
                                           : 8'(m_pat[i] * 2);
          else if (m_mode[i] == 2'd3)
            m_pat[i] = 8'hFF - m_pat[i];
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] s0,
                             input logic [1:0] s1,
                             input logic [1:0] s2);
    rst = 1'b0;
    sel[0] = s0; sel[1] = s1; sel[2] = s2;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel[0] = 2'd2; sel[1] = 2'd3; sel[2] = 2'd1;
    step();
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_led[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset led_%0d got %h exp 00", i, w_led[i]);
      end
    end
    apply_reset(2'd0, 2'd0, 2'd0);
  endtask

  task automatic test_idle();
    for (int c = 0; c < 100; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (w_led[i] !== 8'h00) begin
          errors++;
          $display("FAIL idle led_%0d cyc %0d got %h exp 00",
                   i, c, w_led[i]);
        end
      end
      checks++;
      if (dut.w_tick !== (m_cnt == TD - 1)) begin
        errors++;
        $display("FAIL idle tick cyc %0d got %b exp %b",
                 c, dut.w_tick, (m_cnt == TD - 1));
      end
    end
  endtask

  task automatic test_patterns();
    apply_reset(2'd2, 2'd3, 2'd1);
    step();
    checks++;
    if (w_led[0] !== 8'h01) begin
      errors++;
      $display("FAIL run_first got %h exp 01", w_led[0]);
    end
    for (int c = 0; c < 60; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (w_led[i] !== m_pat[i]) begin
          errors++;
          $display("FAIL pattern led_%0d cyc %0d got %h exp %h",
                   i, c, w_led[i], m_pat[i]);
        end
      end
    end
  endtask

  task automatic test_change_on_tick();
    int n;
    logic [7:0] exp_seq [3];
    apply_reset(2'd2, 2'd0, 2'd0);
    n = 0;
    while (!(m_pat[0] == 8'h08 && m_cnt == TD - 1) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL chg_setup timeout got %0d exp <200", n);
    end
    exp_seq[0] = 8'hFF; exp_seq[1] = 8'h01; exp_seq[2] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      sel[0] = (k == 0) ? 2'd3 : 2'd2;
      step();
      checks++;
      if (w_led[0] !== exp_seq[k]) begin
        errors++;
        $display("FAIL chg_seq%0d got %h exp %h",
                 k, w_led[0], exp_seq[k]);
      end
    end
    n = 0;
    while (m_cnt != 0 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (w_led[0] !== 8'h02) begin
      errors++;
      $display("FAIL chg_adv got %h exp 02", w_led[0]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(2'd2, 2'd3, 2'd1);
    for (int c = 0; c < 9; c++) step();
    #3;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_led[i] !== 8'h00) begin
        errors++;
        $display("FAIL async_rst led_%0d got %h exp 00", i, w_led[i]);
      end
    end
    model_reset();
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_led[i] !== m_pat[i]) begin
        errors++;
        $display("FAIL restart led_%0d got %h exp %h",
                 i, w_led[i], m_pat[i]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset(2'd0, 2'd0, 2'd0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 7) == 0) sel[i] = 2'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        step();
        rst = 1'b1;
      end
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (w_led[i] !== m_pat[i]) begin
          errors++;
          $display("FAIL random led_%0d cyc %0d got %h exp %h",
                   i, c, w_led[i], m_pat[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    sel[0] = 2'd0; sel[1] = 2'd0; sel[2] = 2'd0;
    model_reset();
    test_reset();
    test_idle();
    test_patterns();
    test_change_on_tick();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
